// File: rtl/list_cmd_queue.sv
// list_cmd_queue: buffered valid/ready front-end for the list engine.
// Commands are queued, issued one at a time on the list op_en/op_done
// handshake, and every result (including Find_all_index streams) is
// collected into a response FIFO.
module list_cmd_queue #(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned LENGTH     = 8,
  parameter int unsigned CMD_DEPTH  = 4,
  parameter int unsigned RSP_DEPTH  = 8,
  localparam int unsigned LENGTH_WIDTH = $clog2(LENGTH),
  localparam int unsigned CNT_WIDTH    = $clog2(CMD_DEPTH + 1)
) (
  input  logic                               clk,
  input  logic                               rst,
  input  logic                               cmd_valid,
  output logic                               cmd_ready,
  input  logic [2:0]                         cmd_op,
  input  logic [DATA_WIDTH-1:0]              cmd_data,
  input  logic [LENGTH_WIDTH-1:0]            cmd_index,
  output logic [2:0]                         list_op_sel,
  output logic                               list_op_en,
  output logic [DATA_WIDTH-1:0]              list_data_in,
  output logic [LENGTH_WIDTH-1:0]            list_index_in,
  input  logic [LENGTH_WIDTH+DATA_WIDTH-1:0] list_data_out,
  input  logic                               list_op_done,
  input  logic                               list_op_in_progress,
  input  logic                               list_op_error,
  output logic                               rsp_valid,
  input  logic                               rsp_ready,
  output logic [LENGTH_WIDTH+DATA_WIDTH-1:0] rsp_data,
  output logic                               rsp_error,
  output logic                               rsp_last,
  output logic [2:0]                         rsp_op,
  output logic                               busy,
  output logic [CNT_WIDTH-1:0]               cmd_count
);

  localparam int unsigned ResW  = LENGTH_WIDTH + DATA_WIDTH;
  localparam int unsigned CmdAw = $clog2(CMD_DEPTH);
  localparam int unsigned RspAw = $clog2(RSP_DEPTH);
  localparam int unsigned CmdW  = 3 + DATA_WIDTH + LENGTH_WIDTH;
  localparam int unsigned RspW  = 3 + 2 + ResW;

  localparam logic [CmdAw:0] CmdPtrOne = 1;
  localparam logic [RspAw:0] RspPtrOne = 1;

  localparam logic [2:0] OpRead    = 3'd0;
  localparam logic [2:0] OpFindAll = 3'd2;
  localparam logic [2:0] OpFind1st = 3'd3;
  localparam logic [2:0] OpSum     = 3'd4;

  typedef enum logic [1:0] {StIdle, StIssue, StGap} state_e;

  state_e state_q;

  logic [2:0]              op_sel_q;
  logic                    op_en_q;
  logic [DATA_WIDTH-1:0]   data_in_q;
  logic [LENGTH_WIDTH-1:0] index_in_q;

  // Command FIFO
  logic [CmdW-1:0]         cmd_mem_q [CMD_DEPTH];
  logic [CmdAw:0]          cmd_wptr_q, cmd_rptr_q, cmd_fill;
  logic                    cmd_empty, cmd_full, cmd_push, cmd_pop;
  logic [2:0]              head_op;
  logic [DATA_WIDTH-1:0]   head_data;
  logic [LENGTH_WIDTH-1:0] head_index;

  // Response FIFO
  logic [RspW-1:0]         rsp_mem_q [RSP_DEPTH];
  logic [RspAw:0]          rsp_wptr_q, rsp_rptr_q, rsp_fill;
  logic                    rsp_empty, rsp_push, rsp_pop;
  logic [31:0]             rsp_free;
  logic [RspW-1:0]         rsp_entry, rsp_head;
  logic [ResW-1:0]         entry_data;
  logic                    entry_last;

  logic                    space_ok, issue_go;

  // Command FIFO status and head decode
  always_comb begin
    cmd_fill  = cmd_wptr_q - cmd_rptr_q;
    cmd_empty = (cmd_wptr_q == cmd_rptr_q);
    cmd_full  = (cmd_wptr_q[CmdAw] != cmd_rptr_q[CmdAw]) &&
                (cmd_wptr_q[CmdAw-1:0] == cmd_rptr_q[CmdAw-1:0]);
    {head_op, head_data, head_index} = cmd_mem_q[cmd_rptr_q[CmdAw-1:0]];
  end

  assign cmd_ready = ~cmd_full;
  assign cmd_push  = cmd_valid & ~cmd_full;
  assign cmd_pop   = issue_go;
  assign cmd_count = CNT_WIDTH'(cmd_fill);

  // Response FIFO status; Find_all_index may return up to LENGTH entries
  always_comb begin
    rsp_fill  = rsp_wptr_q - rsp_rptr_q;
    rsp_empty = (rsp_wptr_q == rsp_rptr_q);
    rsp_free  = RSP_DEPTH - 32'(rsp_fill);
    space_ok  = (head_op == OpFindAll) ? (rsp_free >= LENGTH) : (rsp_free != 32'd0);
    issue_go  = (state_q != StIssue) && !cmd_empty && space_ok;
  end

  // Build the response entry for the op currently held on the list
  always_comb begin
    unique case (op_sel_q)
      OpRead, OpFindAll, OpFind1st, OpSum: entry_data = list_data_out;
      default:                             entry_data = '0;
    endcase
    entry_last = (op_sel_q == OpFindAll) ? ~list_op_in_progress : 1'b1;
    rsp_entry  = {op_sel_q, entry_last, list_op_error, entry_data};
    rsp_push   = (state_q == StIssue) && list_op_done;
  end

  // Head of the response FIFO, forced to zero when empty
  always_comb begin
    rsp_head = rsp_empty ? '0 : rsp_mem_q[rsp_rptr_q[RspAw-1:0]];
    {rsp_op, rsp_last, rsp_error, rsp_data} = rsp_head;
  end

  assign rsp_valid = ~rsp_empty;
  assign rsp_pop   = rsp_valid & rsp_ready;

  assign list_op_sel   = op_sel_q;
  assign list_op_en    = op_en_q;
  assign list_data_in  = data_in_q;
  assign list_index_in = index_in_q;
  assign busy          = (state_q != StIdle) || !cmd_empty || !rsp_empty;

  // FIFO pointers; the extra top bit separates full from empty
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cmd_wptr_q <= '0;
      cmd_rptr_q <= '0;
      rsp_wptr_q <= '0;
      rsp_rptr_q <= '0;
    end else begin
      if (cmd_push) cmd_wptr_q <= cmd_wptr_q + CmdPtrOne;
      if (cmd_pop)  cmd_rptr_q <= cmd_rptr_q + CmdPtrOne;
      if (rsp_push) rsp_wptr_q <= rsp_wptr_q + RspPtrOne;
      if (rsp_pop)  rsp_rptr_q <= rsp_rptr_q + RspPtrOne;
    end
  end

  // FIFO storage; contents are don't-care while the pointers say empty
  always_ff @(posedge clk) begin
    if (cmd_push) cmd_mem_q[cmd_wptr_q[CmdAw-1:0]] <= {cmd_op, cmd_data, cmd_index};
    if (rsp_push) rsp_mem_q[rsp_wptr_q[RspAw-1:0]] <= rsp_entry;
  end

  // Issue FSM with registered list-side outputs. GAP shares IDLE's issue
  // decision so back-to-back commands see exactly one op_en-low cycle.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= StIdle;
      op_sel_q   <= '0;
      op_en_q    <= 1'b0;
      data_in_q  <= '0;
      index_in_q <= '0;
    end else begin
      unique case (state_q)
        StIdle, StGap: begin
          if (issue_go) begin
            state_q    <= StIssue;
            op_en_q    <= 1'b1;
            op_sel_q   <= head_op;
            data_in_q  <= head_data;
            index_in_q <= head_index;
          end else begin
            state_q <= StIdle;
            op_en_q <= 1'b0;
          end
        end
        StIssue: begin
          if (list_op_done && entry_last) begin
            state_q <= StGap;
            op_en_q <= 1'b0;
          end
        end
        default: begin
          state_q <= StIdle;
          op_en_q <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: doc/list_cmd_queue.md
Name: list_cmd_queue

Overview:
- Command front-end that sits directly upstream of the `list` engine.
- Accepts list operations from a valid/ready producer and buffers them in a command FIFO.
- Issues each operation to the list using the list's op_en/op_done/op_in_progress protocol.
- Collects every result, including multi-result Find_all_index streams, into a response FIFO drained through valid/ready. This decouples software-style masters from the list's hold-until-done handshake.

Parameters:
- DATA_WIDTH, 8, list element width; must match the attached list.
- LENGTH, 8, list capacity; LENGTH_WIDTH = $clog2(LENGTH).
- CMD_DEPTH, 4, command FIFO entries; power of 2, at least 2.
- RSP_DEPTH, 8, response FIFO entries; must be >= LENGTH.

Ports:
- clk  in  1  clock
- rst  in  1  reset, asynchronous, active-low (0 = reset)
- cmd_valid  in  1  command offered
- cmd_ready  out  1  command FIFO can accept
- cmd_op  in  3  0 Read, 1 Insert, 2 Find_all_index, 3 Find_1st_index, 4 Sum, 5 Sort_Asc, 6 Sort_Des, 7 Delete
- cmd_data  in  DATA_WIDTH  value for Insert/Find
- cmd_index  in  LENGTH_WIDTH  index for Read/Insert/Delete
- list_op_sel  out  3  to list op_sel
- list_op_en  out  1  to list op_en
- list_data_in  out  DATA_WIDTH  to list data_in
- list_index_in  out  LENGTH_WIDTH  to list index_in
- list_data_out  in  LENGTH_WIDTH+DATA_WIDTH  from list data_out
- list_op_done  in  1  from list
- list_op_in_progress  in  1  from list
- list_op_error  in  1  from list
- rsp_valid  out  1  response available
- rsp_ready  in  1  consumer accepts
- rsp_data  out  LENGTH_WIDTH+DATA_WIDTH  result
- rsp_error  out  1  list op_error captured
- rsp_last  out  1  final response of its command
- rsp_op  out  3  opcode the response belongs to
- busy  out  1  FSM not IDLE, or either FIFO non-empty
- cmd_count  out  $clog2(CMD_DEPTH+1)  command FIFO occupancy

Behaviour:
- Reset (rst=0, async): all outputs are 0, except cmd_ready, which is 1. Both FIFOs are emptied and the FSM goes to IDLE. list_op_en falls immediately, without waiting for a clock edge, even mid-operation.
- Command FIFO:
  - push on cmd_valid & cmd_ready;
  - cmd_ready = (cmd_count < CMD_DEPTH), with no combinational pop-through;
  - push and pop in the same cycle are both honoured.
- FSM states: IDLE, ISSUE, GAP.
- IDLE -> ISSUE when the command FIFO is non-empty and response space is sufficient:
  - free >= LENGTH for Find_all_index;
  - free >= 1 for any other op.
- On that edge the FIFO is popped and list_op_sel/list_data_in/list_index_in/list_op_en=1 are registered.
- Earliest list_op_en is the edge after the accept edge.
- The list-side outputs are held stable throughout ISSUE.
- ISSUE, on each cycle with list_op_done=1, pushes one response entry:
  - rsp_data = list_data_out for Read, Find_all_index, Find_1st_index and Sum; 0 for Insert, Sort_Asc, Sort_Des and Delete;
  - rsp_error = list_op_error;
  - rsp_op = the issued opcode;
  - rsp_last = 1, except for Find_all_index, where rsp_last = ~list_op_in_progress.
- ISSUE -> GAP on the op_done cycle that has rsp_last=1. Find_all_index stays in ISSUE across intermediate op_done pulses. A not-found result (op_error with op_done) is a single last entry.
- GAP drives list_op_en=0 for exactly 1 cycle, then returns to IDLE. Back-to-back commands are therefore separated by one op_en-low cycle.
- Response FIFO:
  - rsp_valid = non-empty; the head is presented on the rsp_* outputs;
  - pop on rsp_valid & rsp_ready;
  - push and pop in the same cycle are allowed;
  - overflow is impossible by the issue rule;
  - a response is visible the cycle after its op_done is sampled.
- rsp_ready low never stalls the list mid-operation; it only blocks new issues.
- Widths: cmd_count saturates at CMD_DEPTH. FIFO pointers wrap modulo depth, with an extra wrap bit for the full/empty distinction.

Test Plan:
- Insert(0,5), Insert(1,7), Read(1) back-to-back, rsp_ready=1 -> 3 responses:
  - op=1, data=0, err=0, last=1;
  - op=1, data=0, err=0, last=1;
  - op=0, data=7, err=0, last=1;
  - list_op_en low for exactly 1 cycle between the commands.
- List [5,7,5], Find_all_index(5) -> responses data=0 last=0, then data=2 last=1, both err=0. Find_all_index(9) -> single response err=1, last=1.
- List of 3 elements, Read(6) and Delete(6) -> each gives err=1, last=1; Sum afterwards -> data=17, err=0.
- rsp_ready=0, list [5,7,5], issue two Find_all_index(5) -> first issued (free=8), 2 entries buffered; second is not issued (free=6<8) and list_op_en stays 0. Raising rsp_ready -> drains, then the second issues.
- List stub never asserts op_done, 6 commands offered -> first issued, next 4 accepted, cmd_count=4, sixth sees cmd_ready=0.
- Assert rst=0 mid Find_all_index, between op_done pulses -> list_op_en, rsp_valid and cmd_count are 0 before the next clock edge, and the FSM is in IDLE after release.
